// File: rtl/img_pkg.sv
// Shared image-pipeline constants and types used by the gradient and Sqrt stages.
package img_pkg;

    localparam int IMG_G_WIDTH   = 11;
    localparam int IMG_OUT_WIDTH = 21;
    localparam int IMG_CNT_WIDTH = 16;

    typedef logic signed [IMG_G_WIDTH-1:0] grad_t;

    typedef struct packed {
        logic sof;
        logic eol;
    } sband_t;

endpackage

// File: rtl/grad_mag_sq_if.sv
// Stream handshake bundle for the squared-gradient-magnitude stage.
interface grad_mag_sq_if #(
    parameter int G_WIDTH   = img_pkg::IMG_G_WIDTH,
    parameter int OUT_WIDTH = img_pkg::IMG_OUT_WIDTH,
    parameter int CNT_WIDTH = img_pkg::IMG_CNT_WIDTH
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [G_WIDTH-1:0]  in_gx;
    logic signed [G_WIDTH-1:0]  in_gy;
    logic                       in_sof;
    logic                       in_eol;
    logic                       out_valid;
    logic                       out_ready;
    logic [OUT_WIDTH-1:0]       out_radical;
    logic                       out_sof;
    logic                       out_eol;
    logic                       out_sat;
    logic [CNT_WIDTH-1:0]       sat_cnt;

    modport master (
        output in_valid, in_gx, in_gy, in_sof, in_eol, out_ready,
        input  in_ready, out_valid, out_radical, out_sof, out_eol, out_sat, sat_cnt
    );

    modport slave (
        input  in_valid, in_gx, in_gy, in_sof, in_eol, out_ready,
        output in_ready, out_valid, out_radical, out_sof, out_eol, out_sat, sat_cnt
    );
endinterface

// File: rtl/grad_abs_sq.sv
// One gradient channel: absolute value (first stage) then square (second stage).
module grad_abs_sq #(
    parameter int G_WIDTH = 11
) (
    input  logic                     clk_main,
    input  logic                     en,
    input  logic signed [G_WIDTH-1:0] g,
    output logic [2*G_WIDTH-2:0]     sq
);
    localparam int SQ_W = 2*G_WIDTH-1;

    logic [G_WIDTH-1:0] g_u;
    logic [G_WIDTH-1:0] abs_next;
    logic [G_WIDTH-1:0] abs_reg;
    logic [SQ_W-1:0]    abs_ext;
    logic [SQ_W-1:0]    sq_next;
    logic [SQ_W-1:0]    sq_reg;

    // Unsigned result: the most negative input maps to 2^(G_WIDTH-1) without wrapping.
    assign g_u      = g;
    assign abs_next = g[G_WIDTH-1] ? (~g_u + G_WIDTH'(1)) : g_u;
    assign abs_ext  = {{(SQ_W-G_WIDTH){1'b0}}, abs_reg};
    assign sq_next  = abs_ext * abs_ext;

    always_ff @(posedge clk_main) begin
        if (en) begin
            abs_reg <= abs_next;
            sq_reg  <= sq_next;
        end
    end

    assign sq = sq_reg;
endmodule

// File: rtl/grad_mag_sq.sv
// Pipelined Gx^2+Gy^2 with saturation to the Sqrt radical width, global-stall handshake.
module grad_mag_sq
    import img_pkg::*;
#(
    parameter int G_WIDTH   = IMG_G_WIDTH,
    parameter int OUT_WIDTH = IMG_OUT_WIDTH,
    parameter int CNT_WIDTH = IMG_CNT_WIDTH
) (
    input  logic          clk_main,
    input  logic          sys_rst,
    grad_mag_sq_if.slave  bus
);
    localparam int SQ_W  = 2*G_WIDTH-1;
    localparam int SUM_W = SQ_W+1;
    localparam logic [SUM_W-1:0] SAT_LIM = SUM_W'(1) << OUT_WIDTH;

    logic                    en;
    logic                    v1_reg, v2_reg, v3_reg;
    sband_t                  sb1_reg, sb2_reg, sb3_reg;
    sband_t                  sb_in;
    logic [OUT_WIDTH-1:0]    rad_reg;
    logic [OUT_WIDTH-1:0]    rad_next;
    logic                    sat_reg;
    logic                    sat_next;
    logic [SUM_W-1:0]        sum;
    logic [CNT_WIDTH-1:0]    sat_cnt_reg;

    logic signed [G_WIDTH-1:0] g_in [2];
    logic [SQ_W-1:0]           sq   [2];

    // One enable for the whole pipe: advance whenever the output slot is free or draining.
    assign en = bus.out_ready | ~v3_reg;

    assign g_in[0] = bus.in_gx;
    assign g_in[1] = bus.in_gy;

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        grad_abs_sq #(.G_WIDTH(G_WIDTH)) u_abs_sq (
            .clk_main (clk_main),
            .en       (en),
            .g        (g_in[gi]),
            .sq       (sq[gi])
        );
    end

    assign sb_in    = '{sof: bus.in_sof, eol: bus.in_eol};
    assign sum      = SUM_W'(sq[0]) + SUM_W'(sq[1]);
    assign sat_next = (sum >= SAT_LIM);
    assign rad_next = sat_next ? {OUT_WIDTH{1'b1}} : sum[OUT_WIDTH-1:0];

    always_ff @(posedge clk_main) begin
        if (sys_rst) begin
            v1_reg      <= 1'b0;
            v2_reg      <= 1'b0;
            v3_reg      <= 1'b0;
            sb1_reg     <= '0;
            sb2_reg     <= '0;
            sb3_reg     <= '0;
            rad_reg     <= '0;
            sat_reg     <= 1'b0;
            sat_cnt_reg <= '0;
        end else begin
            if (en) begin
                v1_reg  <= bus.in_valid;
                v2_reg  <= v1_reg;
                v3_reg  <= v2_reg;
                sb1_reg <= sb_in;
                sb2_reg <= sb1_reg;
                sb3_reg <= sb2_reg;
                rad_reg <= rad_next;
                sat_reg <= sat_next;
            end
            // Frame-local count: an sof beat restarts it with its own saturation flag.
            if (v3_reg && bus.out_ready) begin
                if (sb3_reg.sof) begin
                    sat_cnt_reg <= CNT_WIDTH'(sat_reg);
                end else if (sat_reg && (sat_cnt_reg != {CNT_WIDTH{1'b1}})) begin
                    sat_cnt_reg <= sat_cnt_reg + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign bus.in_ready    = en;
    assign bus.out_valid   = v3_reg;
    assign bus.out_radical = rad_reg;
    assign bus.out_sof     = sb3_reg.sof;
    assign bus.out_eol     = sb3_reg.eol;
    assign bus.out_sat     = sat_reg;
    assign bus.sat_cnt     = sat_cnt_reg;
endmodule

// File: tb/tb_grad_mag_sq.sv
// Directed bench for grad_mag_sq: latency, saturation, frame counter, stalls, bubbles, reset.
module tb_grad_mag_sq;
    import img_pkg::*;

    logic clk_main = 1'b0;
    logic sys_rst  = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk_main = ~clk_main;

    grad_mag_sq_if #(.G_WIDTH(11), .OUT_WIDTH(21), .CNT_WIDTH(16)) bus ();

    grad_mag_sq #(.G_WIDTH(11), .OUT_WIDTH(21), .CNT_WIDTH(16)) dut (
        .clk_main (clk_main),
        .sys_rst  (sys_rst),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int gx, input int gy, input logic v, input logic sof, input logic eol);
        bus.in_valid = v;
        bus.in_gx    = 11'(gx);
        bus.in_gy    = 11'(gy);
        bus.in_sof   = sof;
        bus.in_eol   = eol;
    endtask

    // Single isolated beat with out_ready high: output must appear exactly 3 cycles later.
    task automatic beat(input string tag, input int gx, input int gy, input logic sof,
                        input logic eol, input int exp_rad, input logic exp_sat);
        drive(gx, gy, 1'b1, sof, eol);
        tick();
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        chk({tag, "_early"}, 32'(bus.out_valid), 0);
        tick();
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_radical"}, 32'(bus.out_radical), 32'(exp_rad));
        chk({tag, "_sat"}, 32'(bus.out_sat), 32'(exp_sat));
        chk({tag, "_sof"}, 32'(bus.out_sof), 32'(sof));
        chk({tag, "_eol"}, 32'(bus.out_eol), 32'(eol));
        tick();
        chk({tag, "_after"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        int si, ri, cyc;
        logic accept, prev_stall;
        logic [20:0] prev_rad;

        drive(0, 0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        sys_rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_radical", 32'(bus.out_radical), 0);
        chk("rst_sof", 32'(bus.out_sof), 0);
        chk("rst_eol", 32'(bus.out_eol), 0);
        chk("rst_sat", 32'(bus.out_sat), 0);
        chk("rst_sat_cnt", 32'(bus.sat_cnt), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        beat("basic", 3, -4, 1'b0, 1'b0, 25, 1'b0);
        beat("maxleg_a", -1020, 1020, 1'b0, 1'b0, 2080800, 1'b0);
        beat("maxleg_b", 1023, 1023, 1'b0, 1'b0, 2093058, 1'b0);
        beat("neg_edge_x", -1024, 0, 1'b0, 1'b0, 1048576, 1'b0);
        beat("near_sat", -1024, 1023, 1'b0, 1'b0, 2095105, 1'b0);
        chk("cnt_nosat", 32'(bus.sat_cnt), 0);

        beat("sat_sof", -1024, -1024, 1'b1, 1'b0, 2097151, 1'b1);
        chk("cnt_sat1", 32'(bus.sat_cnt), 1);
        beat("sat_again", -1024, -1024, 1'b0, 1'b0, 2097151, 1'b1);
        chk("cnt_sat2", 32'(bus.sat_cnt), 2);
        beat("sof_eol_zero", 0, 0, 1'b1, 1'b1, 0, 1'b0);
        chk("cnt_restart", 32'(bus.sat_cnt), 0);

        // Back-pressure stream: beats k=0..9, out_ready low during loop cycles 4..7.
        si = 0; ri = 0; cyc = 0; prev_stall = 1'b0; prev_rad = '0;
        while (ri < 10 && cyc < 100) begin
            bus.out_ready = !(cyc >= 4 && cyc <= 7);
            if (si < 10) drive(si, 0, 1'b1, si == 0, si == 9);
            else         drive(0, 0, 1'b0, 1'b0, 1'b0);
            #1;
            accept = bus.in_valid && bus.in_ready;
            if (prev_stall && bus.out_valid)
                chk("bp_hold_radical", 32'(bus.out_radical), 32'(prev_rad));
            if (bus.out_valid && !bus.out_ready)
                chk("bp_in_ready_low", 32'(bus.in_ready), 0);
            if (bus.out_valid && bus.out_ready) begin
                chk("bp_radical", 32'(bus.out_radical), 32'(ri*ri));
                chk("bp_sof", 32'(bus.out_sof), 32'(ri == 0));
                chk("bp_eol", 32'(bus.out_eol), 32'(ri == 9));
                ri++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_rad   = bus.out_radical;
            tick();
            if (accept) si++;
            cyc++;
        end
        chk("bp_all_received", 32'(ri), 10);
        chk("bp_all_sent", 32'(si), 10);
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_no_dup0", 32'(bus.out_valid), 0);
        tick();
        chk("bp_no_dup1", 32'(bus.out_valid), 0);

        // Bubbles: valid pattern 1,0,1 with junk data in the gap.
        drive(1, 0, 1'b1, 1'b0, 1'b0); tick();
        drive(7, 7, 1'b0, 1'b0, 1'b0); tick();
        drive(2, 0, 1'b1, 1'b0, 1'b0); tick();
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        chk("bub_v0", 32'(bus.out_valid), 1);
        chk("bub_r0", 32'(bus.out_radical), 1);
        tick();
        chk("bub_v1", 32'(bus.out_valid), 0);
        tick();
        chk("bub_v2", 32'(bus.out_valid), 1);
        chk("bub_r2", 32'(bus.out_radical), 4);
        tick();
        chk("bub_v3", 32'(bus.out_valid), 0);

        // Reset with two beats in flight, after loading the frame counter.
        beat("pre_rst_sat", -1024, -1024, 1'b1, 1'b0, 2097151, 1'b1);
        chk("pre_rst_cnt", 32'(bus.sat_cnt), 1);
        drive(5, 0, 1'b1, 1'b0, 1'b0); tick();
        drive(6, 0, 1'b1, 1'b0, 1'b0); tick();
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_cnt", 32'(bus.sat_cnt), 0);
        drive(7, 1, 1'b1, 1'b0, 1'b0); tick();
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_v1", 32'(bus.out_valid), 0);
        tick();
        chk("post_rst_v2", 32'(bus.out_valid), 0);
        tick();
        chk("post_rst_v3", 32'(bus.out_valid), 1);
        chk("post_rst_rad", 32'(bus.out_radical), 50);
        tick();
        chk("post_rst_v4", 32'(bus.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/grad_mag_sq.md
Name: grad_mag_sq

Overview:
- Pipelined stage that converts signed Sobel gradients (Gx, Gy) into the squared magnitude Gx²+Gy².
- Output is a 21-bit unsigned radical that feeds the downstream Sqrt stage directly (21-bit radical, 11-bit q, 12-bit remainder).
- Valid/ready handshake with back-pressure; frame sideband signals (sof, eol) pass through aligned with the data.
- Per-frame saturation counter for bench and debug visibility.

Parameters:
- G_WIDTH, 11, signed gradient width; range -1024..1023.
- OUT_WIDTH, 21, radical width; must equal the Sqrt width parameter.
- CNT_WIDTH, 16, saturation counter width.

Ports:
- clk_main  in  1  single clock; all logic rising-edge.
- sys_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_gx  in  G_WIDTH  signed horizontal gradient.
- in_gy  in  G_WIDTH  signed vertical gradient.
- in_sof  in  1  first pixel of frame.
- in_eol  in  1  last pixel of line.
- out_valid  out  1  radical valid.
- out_ready  in  1  downstream accepts.
- out_radical  out  OUT_WIDTH  Gx²+Gy², saturated.
- out_sof  out  1  aligned sof.
- out_eol  out  1  aligned eol.
- out_sat  out  1  this beat was saturated.
- sat_cnt  out  CNT_WIDTH  saturated beats in current frame.

Behaviour:
- One clock domain. Reset is synchronous and active-high: sys_rst sampled high on a clk_main rising edge clears state.
- Reset values:
  - All stage valid bits 0.
  - out_valid 0, out_radical 0, out_sof 0, out_eol 0, out_sat 0, sat_cnt 0.
  - in_ready follows the enable equation below, so it reads 1 after reset.
- Pipeline, 3 register stages:
  - S1 registers |gx|, |gy| as G_WIDTH-bit unsigned. |-1024| = 1024; no wrap.
  - S2 registers gx², gy², each 2*G_WIDTH-1 = 21 bits unsigned (max 1048576).
  - S3 registers the 22-bit sum, saturated to OUT_WIDTH bits.
- Saturation:
  - If the sum ≥ 2^OUT_WIDTH, out_radical = 2^OUT_WIDTH-1 and out_sat = 1.
  - Only the case gx = gy = -1024 (sum 2097152) saturates.
- Latency: 3 cycles from accepted input to out_valid when out_ready is held high.
- Throughput: 1 beat/cycle.
- Handshake:
  - Global enable en = out_ready | ~out_valid.
  - in_ready = en, combinational from out_ready and the S3 valid.
  - When en = 1, all stages advance. A stage's valid bit loads the valid of the stage before it (S1 loads in_valid), so bubbles propagate.
  - When en = 0, every stage holds data, sideband and valid bits.
  - A beat transfers on out_valid & out_ready.
  - Input is accepted only on in_valid & in_ready.
  - Stage data registers may load while their valid bit is 0; stage valid bits must be exact.
  - Held outputs are stable while out_valid=1 and out_ready=0.
- Sideband: sof and eol travel in the valid-qualified pipeline with the data. Each is meaningful only with its beat's valid.
- sat_cnt, updated on each output transfer:
  - Transfer with out_sof=1: sat_cnt = out_sat (restarts the frame count).
  - Otherwise: sat_cnt increments when out_sat=1, saturating at 2^CNT_WIDTH-1 (no wrap).
- Simultaneous events: sof and eol on the same beat are legal; both propagate.
- Reset mid-operation: all in-flight beats are discarded; no partial beat appears after reset.

Decomposition:
- Shared package img_pkg:
  - G_WIDTH and OUT_WIDTH constants.
  - Typedef for the sideband struct {sof, eol}.
  - Typedef for the signed gradient.
  - These constants are shared with the Sqrt instantiation.
- One sub-module, grad_abs_sq:
  - Per-channel abs (S1) and square (S2), with stage registers and enable input.
  - Instantiated twice (gx, gy).
  - Top level holds the valid chain, sum/saturation, handshake and sat_cnt.

Test Plan:
- Basic: gx=3, gy=-4, out_ready=1 -> 3 cycles later out_radical=25, out_sat=0.
- Max legal: gx=-1020, gy=1020 -> out_radical=2080800. Then gx=1023, gy=1023 -> 2093058.
- Saturation: sof=1 with gx=-1024, gy=-1024 -> out_radical=2097151, out_sat=1, sat_cnt=1. Repeat the saturating beat without sof -> sat_cnt=2. Next sof beat with gx=gy=0 -> out_radical=0, sat_cnt=0.
- Back-pressure:
  - Stream 10 beats (gx=k, gy=0, k=0..9) and drop out_ready for 4 cycles mid-stream.
  - Required: in_ready=0 during stall once S3 is valid; no beat lost or duplicated.
  - Output sequence is 0,1,4,...,81 with sof/eol aligned.
- Bubbles: in_valid toggling 1,0,1 -> output valid pattern 1,0,1, delayed 3 cycles.
- Reset mid-stream: assert sys_rst for 1 cycle with 2 beats in flight -> next cycle out_valid=0, sat_cnt=0. The first beat after release appears 3 cycles after acceptance.
